// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO. Each stored word becomes one frame,
// and frames run back-to-back while the FIFO stays non-empty.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [DATA_BITS-1:0]             wr_data,
  output logic                             full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow,
  output logic                             busy,
  output logic                             txd
);

  // state     | meaning
  // ST_IDLE   | line high, waiting for a stored word
  // ST_START  | start bit (low)
  // ST_DATA   | data bits, LSB first
  // ST_PARITY | parity bit (only when PARITY != 0)
  // ST_STOP   | stop bit(s) (high)

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int NW  = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gConfigError
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

  state_e               state, nextState;
  logic [BW-1:0]        baudCnt;
  logic                 tick;
  logic [NW-1:0]        bitCnt;
  logic                 stopCnt;
  logic                 lastBit, lastStop;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parityBit;
  logic                 txdNext;
  logic                 pop, wrAccept;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wrPtr, rdPtr;
  logic [CW-1:0]        count;

  assign tick     = (baudCnt == BAUD_LAST);
  assign lastBit  = (bitCnt == NW'(DATA_BITS - 1));
  assign lastStop = (stopCnt == 1'(STOP_BITS - 1));

  assign full       = (count == CW'(FIFO_DEPTH));
  assign fifo_count = count;
  assign wrAccept   = wr_en && !full;
  assign busy       = (state != ST_IDLE) || (count != '0);

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    txdNext   = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          nextState = ST_START;
        end
      end
      ST_START: begin
        txdNext = 1'b0;
        if (tick) nextState = ST_DATA;
      end
      ST_DATA: begin
        txdNext = shiftReg[0];
        if (tick && lastBit) nextState = (PARITY != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        txdNext = parityBit;
        if (tick) nextState = ST_STOP;
      end
      ST_STOP: begin
        if (tick && lastStop) begin
          if (count != '0) begin
            pop       = 1'b1;
            nextState = ST_START;
          end else begin
            nextState = ST_IDLE;
          end
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      txd       <= 1'b1;
      baudCnt   <= '0;
      bitCnt    <= '0;
      stopCnt   <= 1'b0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
    end else begin
      state <= nextState;
      txd   <= txdNext;

      if (state == ST_IDLE || tick) baudCnt <= '0;
      else                          baudCnt <= baudCnt + BW'(1);

      if (state != ST_DATA) bitCnt <= '0;
      else if (tick)        bitCnt <= bitCnt + NW'(1);

      if (state != ST_STOP) stopCnt <= 1'b0;
      else if (tick)        stopCnt <= ~stopCnt;

      if (pop) begin
        shiftReg  <= mem[rdPtr];
        parityBit <= (^mem[rdPtr]) ^ (PARITY == 1);
      end else if (state == ST_DATA && tick) begin
        shiftReg <= shiftReg >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + PW'(1);
      if (pop)      rdPtr <= rdPtr + PW'(1);
      unique case ({wrAccept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule
